// File: rtl/vram_arbiter.sv
// Arbitrates the single-port CHIP-8 RAM between VGA scan-out (via a one-byte
// read cache) and the CPU load/store unit, with a bounded CPU wait.
module vram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vga_read,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic [DATA_WIDTH-1:0] vga_data,
  output logic                  vga_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VGA_RD = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WAIT);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
  logic                   cache_valid_q, cache_valid_d;
  logic [ADDR_WIDTH-1:0]  cache_addr_q, cache_addr_d;
  logic [DATA_WIDTH-1:0]  cache_data_q, cache_data_d;
  logic [CNT_WIDTH-1:0]   starve_q, starve_d;
  logic                   cpu_ack_q, cpu_ack_d;
  logic [DATA_WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;

  logic vga_hit;
  logic fill_in_flight;
  logic vga_miss;
  logic cpu_pend;
  logic force_cpu;
  logic grant_cpu;
  logic grant_vga;
  logic cpu_wr_grant;

  // A miss whose fill is already returning this cycle must not be re-issued.
  assign vga_hit        = vga_read & cache_valid_q & (cache_addr_q == vga_addr);
  assign fill_in_flight = (state_q == VGA_RD) & (pend_addr_q == vga_addr);
  assign vga_miss       = vga_read & ~vga_hit & ~fill_in_flight;
  assign cpu_pend       = cpu_req & ((state_q == IDLE) | (state_q == VGA_RD)) & ~cpu_ack_q;
  assign force_cpu      = vga_miss & cpu_pend & (starve_q == MAX_CNT);

  // Grants are suppressed while reset is held so the RAM sees no strobe.
  assign grant_cpu    = reset_n & cpu_pend & (force_cpu | ~vga_miss);
  assign grant_vga    = reset_n & vga_miss & ~force_cpu;
  assign cpu_wr_grant = grant_cpu & cpu_we;

  assign vga_valid = vga_hit;
  assign vga_data  = cache_data_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_vga) begin
      mem_en   = 1'b1;
      mem_addr = vga_addr;
    end else if (grant_cpu) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d       = IDLE;
    pend_addr_d   = pend_addr_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;
    starve_d      = starve_q;
    cpu_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;

    if (grant_vga) begin
      state_d     = VGA_RD;
      pend_addr_d = vga_addr;
    end else if (grant_cpu) begin
      state_d = cpu_we ? CPU_WR : CPU_RD;
    end

    // A write landing on the byte being filled overrides the stale RAM data.
    if (state_q == VGA_RD) begin
      cache_valid_d = 1'b1;
      cache_addr_d  = pend_addr_q;
      if (cpu_wr_grant && (cpu_addr == pend_addr_q)) begin
        cache_data_d = cpu_wdata;
      end else begin
        cache_data_d = mem_rdata;
      end
    end else if (cpu_wr_grant && cache_valid_q && (cpu_addr == cache_addr_q)) begin
      cache_data_d = cpu_wdata;
    end

    if (state_q == CPU_RD) begin
      cpu_ack_d   = 1'b1;
      cpu_rdata_d = mem_rdata;
    end else if (cpu_wr_grant) begin
      cpu_ack_d = 1'b1;
    end

    if (!cpu_req || grant_cpu) begin
      starve_d = '0;
    end else if (cpu_pend && (starve_q != MAX_CNT)) begin
      starve_d = starve_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pend_addr_q   <= '0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
      starve_q      <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_addr_q   <= pend_addr_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
      starve_q      <= starve_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and randomized checks of vram_arbiter against a behavioural RAM model.
module tb_vram_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vga_read;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ram_loaded = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .vga_read(vga_read), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram[12'h100] <= 8'hA5;
      ram[12'h200] <= 8'h3C;
      ram[12'h300] <= 8'h11;
      ram_loaded   <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // VGA misses every cycle while the CPU waits; the CPU must win on pending cycle MW+1.
  task automatic starve_run(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                            input int base);
    for (int i = 1; i <= MW + 1; i++) begin
      @(negedge clk);
      vga_read  = 1'b1;
      vga_addr  = 12'(12'h400 + base + i);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      #1;
      if (i <= MW) begin
        chk("starve_vga_grant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, vga_addr});
      end else begin
        chk("forced_cpu_grant", {mem_en, mem_we, mem_addr}, {1'b1, we, addr});
        chk("forced_vga_invalid", vga_valid, 1'b0);
        if (we) chk("forced_wdata", mem_wdata, wd);
      end
    end
    @(negedge clk);
    #1;
    chk("vga_regrant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, vga_addr});
    chk("starve_ack_n1", cpu_ack, we);
    if (!we) begin
      @(negedge clk);
      vga_addr = vga_addr + 12'd1;
      #1;
      chk("starve_rd_ack", cpu_ack, 1'b1);
      chk("starve_rd_data", cpu_rdata, exp_rd);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("starve_ack_pulse", cpu_ack, 1'b0);
    $display("tx starve we=%0d addr=%0h", we, addr);
  endtask

  initial begin
    int  wait_cnt;
    bit  busy;
    bit  drop_next;
    int  n_tx;
    logic bad;

    // Reset with active inputs: nothing may reach the RAM or the CPU.
    reset_n = 1'b0; vga_read = 1'b1; vga_addr = 12'h100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h99;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_en", {mem_en, mem_we}, 2'b00);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk("rst_vga_valid", vga_valid, 1'b0);

    // VGA miss on 0x100 then cached.
    @(negedge clk);
    reset_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    chk("vga_first_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 12'h100});
    chk("vga_c0_invalid", vga_valid, 1'b0);
    @(negedge clk); #1;
    chk("vga_c1_no_reissue", mem_en, 1'b0);
    chk("vga_c1_invalid", vga_valid, 1'b0);
    @(negedge clk); #1;
    chk("vga_c2_valid", vga_valid, 1'b1);
    chk("vga_c2_data", vga_data, 8'hA5);

    // CPU read while VGA hits the cache.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    #1;
    chk("cpu_rd_grant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 12'h200});
    chk("hit_valid", vga_valid, 1'b1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) cpu_req = 1'b0;
      #1;
      chk("no_vga_reread", (mem_en && mem_addr == 12'h100), 1'b0);
      if (k == 2) begin
        chk("cpu_rd_ack", cpu_ack, 1'b1);
        chk("cpu_rd_data", cpu_rdata, 8'h3C);
      end else begin
        chk("cpu_rd_ack_low", cpu_ack, 1'b0);
      end
    end

    // Starvation bound: a write, then a read back of it.
    starve_run(1'b1, 12'h050, 8'h77, 8'h00, 0);
    starve_run(1'b0, 12'h050, 8'h00, 8'h77, 12'h40);

    // Write-through to the cached byte.
    @(negedge clk);
    vga_addr = 12'h100; cpu_req = 1'b0;
    #1;
    chk("recache_issue", {mem_en, mem_addr}, {1'b1, 12'h100});
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("recache_data", {vga_valid, vga_data}, {1'b1, 8'hA5});
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h100; cpu_wdata = 8'hFF;
    #1;
    chk("wt_grant", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 12'h100, 8'hFF});
    @(negedge clk); #1;
    chk("wt_ack", cpu_ack, 1'b1);
    chk("wt_vga_data", {vga_valid, vga_data}, {1'b1, 8'hFF});
    chk("wt_no_read", mem_en, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("wt_held", {vga_valid, vga_data, mem_en}, {1'b1, 8'hFF, 1'b0});

    // Fill of 0x300 and a CPU write to 0x300 in the same cycle.
    @(negedge clk);
    vga_addr = 12'h300;
    #1;
    chk("fill_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 12'h300});
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'h5A;
    #1;
    chk("fill_wr_grant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 12'h300});
    @(negedge clk); #1;
    chk("fill_wr_ack", cpu_ack, 1'b1);
    chk("fill_wr_wins", {vga_valid, vga_data}, {1'b1, 8'h5A});
    @(negedge clk);
    cpu_req = 1'b0;

    // Reset during CPU_RD discards the read.
    @(negedge clk);
    vga_read = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    #1;
    chk("rst_rd_grant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 12'h200});
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    vga_read = 1'b1; vga_addr = 12'h300;
    #1;
    chk("rst_mid_ack", cpu_ack, 1'b0);
    chk("rst_mid_rdata", cpu_rdata, 8'h00);
    chk("rst_mid_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 22'h0);
    chk("rst_mid_vga", {vga_valid, vga_data}, 9'h0);
    @(negedge clk);
    reset_n = 1'b1; cpu_req = 1'b0;
    #1;
    chk("rst_cache_invalid", {mem_en, mem_addr, cpu_ack}, {1'b1, 12'h300, 1'b0});

    // Randomized traffic checked for coherence, data and bounded CPU latency.
    busy = 0; drop_next = 0; wait_cnt = 0; n_tx = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      vga_read = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) vga_addr = 12'(12'h100 + $urandom_range(0, 15));
      if (drop_next) begin
        cpu_req   = 1'b0;
        drop_next = 0;
      end else if (!busy && $urandom_range(0, 3) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 12'(12'h100 + $urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
        busy      = 1;
        wait_cnt  = 0;
      end
      #1;
      if (vga_valid) chk("rnd_vga_coherent", vga_data, ram[vga_addr]);
      bad = vga_valid && mem_en && !mem_we && (mem_addr == vga_addr) &&
            !(busy && !cpu_we && cpu_addr == mem_addr);
      chk("rnd_no_redundant_read", bad, 1'b0);
      if (busy) begin
        if (cpu_ack) begin
          if (cpu_we) chk("rnd_wr_data", ram[cpu_addr], cpu_wdata);
          else        chk("rnd_rd_data", cpu_rdata, ram[cpu_addr]);
          chk("rnd_latency", (wait_cnt <= MW + 2), 1'b1);
          n_tx++;
          $display("tx %0d we=%0d addr=%0h data=%0h lat=%0d", n_tx, cpu_we,
                   cpu_addr, cpu_we ? cpu_wdata : cpu_rdata, wait_cnt);
          busy      = 0;
          drop_next = 1;
        end else begin
          wait_cnt++;
          if (wait_cnt > MW + 2) begin
            chk("rnd_cpu_timeout", 1'b0, 1'b1);
            busy      = 0;
            drop_next = 1;
          end
        end
      end else begin
        chk("rnd_ack_idle", cpu_ack, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
